// File: rtl/m_skid_buf.sv
// ---------------------------------------------------------------------------
// m_skid_buf -- two-entry valid/ready skid buffer with fully registered outputs.
//
// Sits in front of a plain enabled register stage. Because in_ready is a
// register, there is no combinational path from out_ready to in_ready, so long
// ready chains are broken here.
//
// Handshake: a beat moves across an interface on a rising clk edge where both
// valid and ready are high. Upstream accept = in_valid && in_ready. Downstream
// transfer = out_valid && out_ready. A producer may not assume a beat was taken
// unless both were high at the edge. In a flush cycle no beat is transferred in
// either direction.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   flush      synchronous clear; drops all held beats, wins over handshakes
//   in_valid   upstream beat valid
//   in_ready   registered; the buffer can take a beat this cycle
//   in_data    upstream beat data
//   out_valid  registered; out_data holds a valid beat
//   out_ready  downstream takes the beat this cycle
//   out_data   registered; driven from the main register
//   occupancy  registered count of held beats (0..2)
// ---------------------------------------------------------------------------
module m_skid_buf #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // EMPTY: nothing held. ONE: main holds the head beat. TWO: main + skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  assign out_data = main_q;

  // out_valid, in_ready and occupancy are updated alongside state so every
  // output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      occupancy <= 2'd0;
      main_q    <= RESET_VAL;
      skid_q    <= RESET_VAL;
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      occupancy <= 2'd0;
      main_q    <= RESET_VAL;
      skid_q    <= RESET_VAL;
    end else begin
      case (state)
        EMPTY: begin
          if (in_valid) begin
            main_q    <= in_data;
            state     <= ONE;
            out_valid <= 1'b1;
            in_ready  <= 1'b1;
            occupancy <= 2'd1;
          end
        end
        ONE: begin
          if (in_valid && out_ready) begin
            // Head leaves while a new beat arrives: occupancy stays 1.
            main_q <= in_data;
          end else if (in_valid) begin
            // Downstream stalled: park the new beat behind the head.
            skid_q    <= in_data;
            state     <= TWO;
            in_ready  <= 1'b0;
            occupancy <= 2'd2;
          end else if (out_ready) begin
            // main_q keeps its old value but is no longer valid.
            state     <= EMPTY;
            out_valid <= 1'b0;
            occupancy <= 2'd0;
          end
        end
        TWO: begin
          // in_ready is low here, so in_valid is not looked at.
          if (out_ready) begin
            main_q    <= skid_q;
            state     <= ONE;
            in_ready  <= 1'b1;
            occupancy <= 2'd1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          occupancy <= 2'd0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // Unknown control inputs after reset would silently corrupt the stream.
  always @(posedge clk) begin
    if (rst_n && $isunknown({in_valid, out_ready, flush})) begin
      $error("m_skid_buf: X/Z on in_valid/out_ready/flush at clock edge");
    end
  end
`endif

endmodule

// File: tb/tb_m_skid_buf.sv
// ---------------------------------------------------------------------------
// tb_m_skid_buf -- bench for m_skid_buf.
// The reference is an ordered queue of accepted beats: its depth is the
// expected occupancy, its head the expected out_data. The driver pushes a beat
// whenever it presents one that the bus accepts; the monitor pops on each
// downstream transfer and compares outputs every cycle.
// ---------------------------------------------------------------------------
module tb_m_skid_buf;
  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'hC3;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  m_skid_buf #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  bit           mon_en = 1'b0;
  bit           accepted;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change on the falling edge; the beat is recorded as accepted when
  // the registered in_ready is high and no flush is offered with it.
  task automatic drive(input bit iv, input logic [W-1:0] d, input bit ordy, input bit fl);
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    accepted  = rst_n && iv && in_ready && !fl;
    if (accepted) exp_q.push_back(d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic expect_out(input string name, input bit v, input logic [W-1:0] d,
                            input logic [1:0] occ, input bit rdy);
    @(posedge clk);
    #3;
    check({name, "_valid"}, out_valid, v);
    if (v) check({name, "_data"}, out_data, d);
    check({name, "_occ"}, occupancy, occ);
    check({name, "_in_ready"}, in_ready, rdy);
  endtask

  // ---------------- monitor ----------------
  // Runs 2 time units after each rising edge; out_ready/flush still hold the
  // values that were in effect at that edge.
  bit           prev_valid = 1'b0;
  logic [W-1:0] prev_data  = '0;
  logic [W-1:0] head;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!mon_en) begin
        prev_valid = 1'b0;
      end else begin
        if (flush) begin
          exp_q.delete();
        end else if (prev_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("xfer_with_empty_model", 1, 0);
          end else begin
            head = exp_q.pop_front();
            check("xfer_data", prev_data, head);
          end
        end else if (prev_valid) begin
          check("stall_stable", out_data, prev_data);
        end
        check("occupancy", occupancy, exp_q.size());
        check("out_valid", out_valid, exp_q.size() > 0);
        check("in_ready", in_ready, exp_q.size() < 2);
        if (exp_q.size() > 0) check("out_data", out_data, exp_q[0]);
        prev_valid = out_valid;
        prev_data  = out_data;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] d;

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #12;
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_occ", occupancy, 0);
    check("reset_out_data", out_data, RV);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Single beat in and out.
    drive(1'b1, 8'h11, 1'b1, 1'b0);
    expect_out("single", 1'b1, 8'h11, 2'd1, 1'b1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    expect_out("single_drain", 1'b0, 8'h00, 2'd0, 1'b1);

    // Back-to-back stream at full rate.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, W'(i), 1'b1, 1'b0);
      expect_out("stream", 1'b1, W'(i), 2'd1, 1'b1);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    idle(1);

    // Stall: third beat is held off, then drained in order.
    drive(1'b1, 8'hA1, 1'b0, 1'b0);
    expect_out("stall1", 1'b1, 8'hA1, 2'd1, 1'b1);
    drive(1'b1, 8'hA2, 1'b0, 1'b0);
    expect_out("stall2", 1'b1, 8'hA1, 2'd2, 1'b0);
    drive(1'b1, 8'hA3, 1'b0, 1'b0);
    expect_out("stall3", 1'b1, 8'hA1, 2'd2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'hA3, 1'b1, 1'b0);
      if (accepted) break;
    end
    check("a3_accepted", accepted, 1);
    idle(0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    idle(1);

    // Flush while full, with a beat offered in the same cycle.
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    drive(1'b1, 8'h66, 1'b0, 1'b0);
    drive(1'b1, 8'h77, 1'b1, 1'b1);
    expect_out("flush", 1'b0, 8'h00, 2'd0, 1'b1);
    check("flush_out_data", out_data, RV);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    idle(2);

    // Asynchronous reset while full.
    drive(1'b1, 8'h21, 1'b0, 1'b0);
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_occ", occupancy, 0);
    check("arst_out_data", out_data, RV);
    exp_q.delete();
    idle(2);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    drive(1'b1, 8'h3C, 1'b1, 1'b0);
    expect_out("post_reset", 1'b1, 8'h3C, 2'd1, 1'b1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    idle(1);

    // Randomised traffic.
    for (int i = 0; i < 10000; i++) begin
      d = W'($urandom);
      drive($urandom_range(0, 99) < 60, d, $urandom_range(0, 99) < 55,
            $urandom_range(0, 63) == 0);
    end
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
